rf_bank_arbiter: RTL and testbench
==================================

RF_BANK_ARBITER -- requirements
Module: rf_bank_arbiter

Interface
REQ-001 SHALL have parameter NUM_OC, default 4, meaning number of operand collectors; each collector has 2 source slots, so there are 2*NUM_OC = 8 requester slots.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Req_Valid, input, 8 bits: request from slot s = 2*oc + src.
REQ-005 SHALL have port Req_Bank, input, 16 bits: 2-bit bank per slot; slot s occupies bits [2s+1:2s].
REQ-006 SHALL have port Req_Row, input, 24 bits: 3-bit row per slot; slot s occupies bits [3s+2:3s].
REQ-007 SHALL have port Req_Grant, output, 8 bits: combinational, same-cycle grant per slot.
REQ-008 SHALL have port WriteValid, input, 1 bit: CDB writeback request.
REQ-009 SHALL have port WriteBank, input, 2 bits: target bank of the writeback.
REQ-010 SHALL have port WriteRow, input, 3 bits: target row of the writeback.
REQ-011 SHALL have port Bank_Rd_Valid, output, 4 bits: registered; one bit per bank.
REQ-012 SHALL have port Bank_Rd_Row, output, 12 bits: registered; 3 bits per bank.
REQ-013 SHALL have port Bank_Rd_Tag, output, 12 bits: registered; 3 bits per bank, holding the winning slot index.
REQ-014 SHALL have port Bank_Wr_Valid, output, 4 bits: registered; one bit per bank.
REQ-015 SHALL have port Bank_Wr_Row, output, 3 bits: registered.
REQ-016 SHALL have port Conflict_Cnt, output, 64 bits: 16 bits per bank.

Function
REQ-017 SHALL arbitrate each bank independently: one grant per bank per cycle.
REQ-018 Handshake: a slot SHALL hold Req_Valid, Req_Bank and Req_Row stable until it is granted; Req_Grant[s] SHALL assert only when Req_Valid[s]=1.
REQ-019 Writeback SHALL have strict priority: when WriteValid=1, bank WriteBank grants no read that cycle.
REQ-020 Read arbitration SHALL be round-robin per bank over the 8 slots, starting at that bank's pointer rr_ptr[b] (3 bits).
REQ-021 On a grant to slot w, rr_ptr[b] SHALL become w+1 mod 8; with no grant, rr_ptr[b] SHALL hold.
REQ-022 Pointer wrap-around: winner 7 -> pointer 0.
REQ-023 Latency: a request granted in cycle N SHALL appear on Bank_Rd_* in cycle N+1 with Bank_Rd_Tag = w; with no grant, Bank_Rd_Valid[b] SHALL be 0.
REQ-024 A write accepted in cycle N SHALL appear on Bank_Wr_Valid[WriteBank] and Bank_Wr_Row in cycle N+1.
REQ-025 Simultaneous same-bank requests: exactly one slot SHALL be granted; the others SHALL wait with no grant.
REQ-026 Simultaneous different-bank requests SHALL all be granted in the same cycle.
REQ-027 Conflict_Cnt[b] SHALL increment by the number of valid requests to bank b that are not granted, saturating at 16'hFFFF with no wrap.
REQ-028 Both source slots of one collector targeting the same bank SHALL be treated as a normal conflict and serialized over two cycles.

Reset
REQ-029 On rst=1 the following SHALL clear to 0: Bank_Rd_Valid, Bank_Rd_Row, Bank_Rd_Tag, Bank_Wr_Valid, Bank_Wr_Row, Conflict_Cnt and every rr_ptr.
REQ-030 While rst=1, Req_Grant SHALL be forced to 0.
REQ-031 Reset mid-operation SHALL drop all in-flight registered outputs; requesters re-present after reset is released.

Structure
REQ-032 A shared package SHALL hold NUM_BANKS=4, BANK_W=2, ROW_W=3, TAG_W=3, CNT_W=16, NUM_SLOTS=8.
REQ-033 SHALL instantiate one sub-module rr_arb8 per bank: 8-bit request vector plus 3-bit pointer in, one-hot grant plus 3-bit index out, purely combinational.
REQ-034 Pointer, output and counter registers SHALL reside in rf_bank_arbiter.

Verification
REQ-035 Slots 0..3 request banks 0..3 (rows 1..4) -> all granted in cycle N; in N+1, Bank_Rd_Valid=4'hF, with tags 0..3 and rows 1..4.
REQ-036 Slots 0, 2 and 5 request bank 1 and are held -> grants in order 0, 2, 5 over 3 cycles; Conflict_Cnt[1] = 2+1 = 3.
REQ-037 WriteValid=1, WriteBank=2, WriteRow=6, plus slot 4 requesting bank 2 -> no grant to slot 4; N+1: Bank_Wr_Valid=4'b0100 and Bank_Wr_Row=6; slot 4 granted in the next cycle the write is absent.
REQ-038 rr_ptr[0]=7 and slots 7 and 0 both requesting bank 0 -> slot 7 granted, then slot 0; pointer ends at 1.
REQ-039 Conflict_Cnt[3] preloaded near 16'hFFFF with a persistent conflict -> counter holds at 16'hFFFF.
REQ-040 rst asserted asynchronously mid-cycle while grants are pending -> all outputs read 0 immediately, and the first grant after release is from pointer 0.

Source files
------------

// File: rtl/rf_bank_arbiter_pkg.sv
// rf_bank_arbiter_pkg: shared sizes and helpers for the register-file bank arbiter.
package rf_bank_arbiter_pkg;
    localparam int NUM_BANKS = 4;
    localparam int BANK_W    = 2;
    localparam int ROW_W     = 3;
    localparam int TAG_W     = 3;
    localparam int CNT_W     = 16;
    localparam int NUM_SLOTS = 8;

    function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_SLOTS-1:0] v);
        popcnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) popcnt += CNT_W'(v[i]);
    endfunction
endpackage

// File: rtl/rf_bank_arbiter_rr_arb8.sv
// rr_arb8: combinational 8-way round-robin picker starting at i_ptr.
module rr_arb8
    import rf_bank_arbiter_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] i_req,
    input  logic [TAG_W-1:0]     i_ptr,
    output logic [NUM_SLOTS-1:0] o_gnt,
    output logic [TAG_W-1:0]     o_idx
);
    // Scan from farthest to nearest so the slot closest to the pointer wins.
    always_comb begin
        o_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (i_req[i_ptr + TAG_W'(i)]) o_idx = i_ptr + TAG_W'(i);
        o_gnt = |i_req ? NUM_SLOTS'(1) << o_idx : '0;
    end
endmodule

// File: rtl/rf_bank_arbiter.sv
// rf_bank_arbiter: per-bank round-robin read arbitration with writeback priority,
// registered bank commands and saturating per-bank conflict counters.
module rf_bank_arbiter
    import rf_bank_arbiter_pkg::*;
#(
    parameter int NUM_OC = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2*NUM_OC-1:0]           Req_Valid,
    input  logic [2*NUM_OC*BANK_W-1:0]    Req_Bank,
    input  logic [2*NUM_OC*ROW_W-1:0]     Req_Row,
    output logic [2*NUM_OC-1:0]           Req_Grant,
    input  logic                          WriteValid,
    input  logic [BANK_W-1:0]             WriteBank,
    input  logic [ROW_W-1:0]              WriteRow,
    output logic [NUM_BANKS-1:0]          Bank_Rd_Valid,
    output logic [NUM_BANKS*ROW_W-1:0]    Bank_Rd_Row,
    output logic [NUM_BANKS*TAG_W-1:0]    Bank_Rd_Tag,
    output logic [NUM_BANKS-1:0]          Bank_Wr_Valid,
    output logic [ROW_W-1:0]              Bank_Wr_Row,
    output logic [NUM_BANKS*CNT_W-1:0]    Conflict_Cnt
);
    logic [NUM_SLOTS-1:0]       w_all [NUM_BANKS];
    logic [NUM_SLOTS-1:0]       w_req [NUM_BANKS];
    logic [NUM_SLOTS-1:0]       w_gnt [NUM_BANKS];
    logic [TAG_W-1:0]           w_idx [NUM_BANKS];
    logic [CNT_W-1:0]           w_cnt_nxt [NUM_BANKS];
    logic [TAG_W-1:0]           r_ptr [NUM_BANKS];
    logic [CNT_W-1:0]           r_cnt [NUM_BANKS];
    logic [NUM_BANKS-1:0]       r_rd_valid;
    logic [NUM_BANKS*ROW_W-1:0] r_rd_row;
    logic [NUM_BANKS*TAG_W-1:0] r_rd_tag;
    logic [NUM_BANKS-1:0]       r_wr_valid;
    logic [ROW_W-1:0]           r_wr_row;

    // A bank being written, or reset, offers no requests to its arbiter.
    always_comb begin
        w_all = '{default: '0};
        w_req = '{default: '0};
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int s = 0; s < NUM_SLOTS; s++)
                w_all[b][s] = Req_Valid[s] && Req_Bank[s*BANK_W +: BANK_W] == BANK_W'(b);
            w_req[b] = (rst || (WriteValid && WriteBank == BANK_W'(b))) ? '0 : w_all[b];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
        rr_arb8 u_arb (
            .i_req(w_req[b]),
            .i_ptr(r_ptr[b]),
            .o_gnt(w_gnt[b]),
            .o_idx(w_idx[b])
        );
    end

    always_comb begin
        Req_Grant = '0;
        for (int b = 0; b < NUM_BANKS; b++) Req_Grant |= w_gnt[b];
    end

    // Losers this cycle = requests to the bank minus the (at most one) winner.
    always_comb begin
        logic [CNT_W:0] sum;
        w_cnt_nxt = '{default: '0};
        for (int b = 0; b < NUM_BANKS; b++) begin
            sum = {1'b0, r_cnt[b]} + {1'b0, popcnt(w_all[b]) - CNT_W'(|w_gnt[b])};
            w_cnt_nxt[b] = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= '0;
            r_rd_row   <= '0;
            r_rd_tag   <= '0;
            r_wr_valid <= '0;
            r_wr_row   <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_ptr[b] <= '0;
                r_cnt[b] <= '0;
            end
        end else begin
            r_wr_valid <= WriteValid ? NUM_BANKS'(1) << WriteBank : '0;
            r_wr_row   <= WriteValid ? WriteRow : r_wr_row;
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_rd_valid[b]              <= |w_gnt[b];
                r_rd_row[b*ROW_W +: ROW_W] <= |w_gnt[b] ? Req_Row[w_idx[b]*ROW_W +: ROW_W] : '0;
                r_rd_tag[b*TAG_W +: TAG_W] <= |w_gnt[b] ? w_idx[b] : '0;
                r_ptr[b]                   <= |w_gnt[b] ? w_idx[b] + TAG_W'(1) : r_ptr[b];
                r_cnt[b]                   <= w_cnt_nxt[b];
            end
        end
    end

    always_comb begin
        Conflict_Cnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) Conflict_Cnt[b*CNT_W +: CNT_W] = r_cnt[b];
    end

    assign Bank_Rd_Valid = r_rd_valid;
    assign Bank_Rd_Row   = r_rd_row;
    assign Bank_Rd_Tag   = r_rd_tag;
    assign Bank_Wr_Valid = r_wr_valid;
    assign Bank_Wr_Row   = r_wr_row;
endmodule

// File: tb/tb_rf_bank_arbiter.sv
// tb_rf_bank_arbiter: directed vectors with hand-computed expectations for rf_bank_arbiter.
module tb_rf_bank_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  Req_Valid = '0;
    logic [15:0] Req_Bank = '0;
    logic [23:0] Req_Row = '0;
    logic [7:0]  Req_Grant;
    logic        WriteValid = 1'b0;
    logic [1:0]  WriteBank = '0;
    logic [2:0]  WriteRow = '0;
    logic [3:0]  Bank_Rd_Valid;
    logic [11:0] Bank_Rd_Row;
    logic [11:0] Bank_Rd_Tag;
    logic [3:0]  Bank_Wr_Valid;
    logic [2:0]  Bank_Wr_Row;
    logic [63:0] Conflict_Cnt;
    int n_run = 0;
    int n_fail = 0;

    rf_bank_arbiter #(.NUM_OC(4)) dut (
        .clk(clk), .rst(rst),
        .Req_Valid(Req_Valid), .Req_Bank(Req_Bank), .Req_Row(Req_Row), .Req_Grant(Req_Grant),
        .WriteValid(WriteValid), .WriteBank(WriteBank), .WriteRow(WriteRow),
        .Bank_Rd_Valid(Bank_Rd_Valid), .Bank_Rd_Row(Bank_Rd_Row), .Bank_Rd_Tag(Bank_Rd_Tag),
        .Bank_Wr_Valid(Bank_Wr_Valid), .Bank_Wr_Row(Bank_Wr_Row), .Conflict_Cnt(Conflict_Cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int s, input logic [1:0] bank, input logic [2:0] row);
        Req_Valid[s] = 1'b1;
        Req_Bank[2*s +: 2] = bank;
        Req_Row[3*s +: 3] = row;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        Req_Valid = '0;
        Req_Bank = '0;
        Req_Row = '0;
        WriteValid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        Req_Valid = 8'hFF;
        #3;
        chk("rst_grant", Req_Grant, 8'h00);
        tick();
        chk("rst_rdv", Bank_Rd_Valid, 4'h0);
        chk("rst_cnt", Conflict_Cnt, 64'h0);
        chk("rst_wrv", Bank_Wr_Valid, 4'h0);
        do_reset();

        for (int s = 0; s < 4; s++) set_req(s, 2'(s), 3'(s + 1));
        #1;
        chk("diff_grant", Req_Grant, 8'h0F);
        tick();
        Req_Valid = '0;
        chk("diff_rdv", Bank_Rd_Valid, 4'hF);
        chk("diff_tag", Bank_Rd_Tag, 12'h688);
        chk("diff_row", Bank_Rd_Row, 12'h8D1);
        chk("diff_cnt", Conflict_Cnt, 64'h0);
        tick();
        chk("idle_rdv", Bank_Rd_Valid, 4'h0);

        do_reset();
        set_req(0, 2'd1, 3'd3);
        set_req(2, 2'd1, 3'd4);
        set_req(5, 2'd1, 3'd7);
        #1;
        chk("conf_g0", Req_Grant, 8'h01);
        tick();
        Req_Valid[0] = 1'b0;
        chk("conf_t0", Bank_Rd_Tag[5:3], 3'd0);
        chk("conf_r0", Bank_Rd_Row[5:3], 3'd3);
        chk("conf_g2", Req_Grant, 8'h04);
        tick();
        Req_Valid[2] = 1'b0;
        chk("conf_t2", Bank_Rd_Tag[5:3], 3'd2);
        chk("conf_g5", Req_Grant, 8'h20);
        tick();
        Req_Valid[5] = 1'b0;
        chk("conf_t5", Bank_Rd_Tag[5:3], 3'd5);
        chk("conf_r5", Bank_Rd_Row[5:3], 3'd7);
        chk("conf_cnt", Conflict_Cnt, 64'h0000_0000_0003_0000);

        do_reset();
        WriteValid = 1'b1;
        WriteBank = 2'd2;
        WriteRow = 3'd6;
        set_req(4, 2'd2, 3'd5);
        #1;
        chk("wr_block", Req_Grant, 8'h00);
        tick();
        WriteValid = 1'b0;
        chk("wr_wrv", Bank_Wr_Valid, 4'b0100);
        chk("wr_row", Bank_Wr_Row, 3'd6);
        chk("wr_rdv", Bank_Rd_Valid, 4'h0);
        chk("wr_cnt", Conflict_Cnt, 64'h0000_0001_0000_0000);
        #1;
        chk("wr_after_g", Req_Grant, 8'h10);
        tick();
        Req_Valid = '0;
        chk("wr_after_rdv", Bank_Rd_Valid, 4'b0100);
        chk("wr_after_tag", Bank_Rd_Tag[8:6], 3'd4);
        chk("wr_after_row", Bank_Rd_Row[8:6], 3'd5);
        chk("wr_done", Bank_Wr_Valid, 4'h0);

        do_reset();
        set_req(6, 2'd0, 3'd1);
        tick();
        Req_Valid = '0;
        set_req(7, 2'd0, 3'd2);
        set_req(0, 2'd0, 3'd3);
        #1;
        chk("wrap_g7", Req_Grant, 8'h80);
        tick();
        Req_Valid[7] = 1'b0;
        chk("wrap_t7", Bank_Rd_Tag[2:0], 3'd7);
        chk("wrap_g0", Req_Grant, 8'h01);
        tick();
        set_req(1, 2'd0, 3'd4);
        #1;
        chk("wrap_ptr1", Req_Grant, 8'h02);
        tick();
        Req_Valid = '0;

        do_reset();
        for (int s = 0; s < 8; s++) set_req(s, 2'd3, 3'(s));
        WriteValid = 1'b1;
        WriteBank = 2'd3;
        #1;
        chk("sat_nogrant", Req_Grant, 8'h00);
        repeat (8191) tick();
        chk("sat_near", Conflict_Cnt[63:48], 16'hFFF8);
        tick();
        chk("sat_hit", Conflict_Cnt[63:48], 16'hFFFF);
        repeat (3) tick();
        chk("sat_hold", Conflict_Cnt[63:48], 16'hFFFF);

        do_reset();
        for (int s = 0; s < 4; s++) set_req(s, 2'(s), 3'(s + 1));
        set_req(4, 2'd0, 3'd5);
        tick();
        Req_Valid[0] = 1'b0;
        chk("ar_pre_rdv", Bank_Rd_Valid, 4'hF);
        chk("ar_pre_cnt", Conflict_Cnt[15:0], 16'd1);
        Req_Valid[0] = 1'b1;
        #1;
        chk("ar_pre_g", Req_Grant, 8'h1E);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_rdv", Bank_Rd_Valid, 4'h0);
        chk("ar_tag", Bank_Rd_Tag, 12'h0);
        chk("ar_cnt", Conflict_Cnt, 64'h0);
        chk("ar_grant", Req_Grant, 8'h00);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_post_g", Req_Grant, 8'h0F);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
